// File: rtl/score_pkg.sv
// Shared definitions for the high-score table sequencer: data widths,
// the erased-flash word value and the sequencer state encoding.
package score_pkg;

  localparam int DW = 16;
  localparam int AW = 23;

  // An erased flash word reads back as all ones.
  localparam logic [DW-1:0] ERASED_WORD = 16'hFFFF;

  typedef enum logic [3:0] {
    S_BOOT    = 4'd0,
    S_RD_REQ  = 4'd1,
    S_RD_WAIT = 4'd2,
    S_IDLE    = 4'd3,
    S_INSERT  = 4'd4,
    S_ER_REQ  = 4'd5,
    S_ER_WAIT = 4'd6,
    S_WR_REQ  = 4'd7,
    S_WR_RISE = 4'd8,
    S_WR_WAIT = 4'd9,
    S_WR_DONE = 4'd10,
    S_ERROR   = 4'd11
  } state_e;

endpackage

// File: rtl/score_table_sequencer_if.sv
// Handshake bundle between the score table sequencer (master) and
// flash_manager (slave).
interface score_table_sequencer_if;
  import score_pkg::*;

  logic          writemode;
  logic          dowrite;
  logic          doread;
  logic [AW-1:0] raddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] frdata;
  logic          fbusy;

  modport master (
    output writemode, dowrite, doread, raddr, wdata,
    input  frdata, fbusy
  );

  modport slave (
    input  writemode, dowrite, doread, raddr, wdata,
    output frdata, fbusy
  );

endinterface

// File: rtl/score_insert.sv
// Combinational sorted insertion: finds the first slot the new score beats
// (strictly), shifts the lower entries down by one and drops the last.
module score_insert
  import score_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0][DW-1:0] table_i,
  input  logic [DW-1:0]            score_i,
  output logic [DEPTH-1:0][DW-1:0] table_o,
  output logic [2:0]               rank_o,
  output logic                     hit_o
);

  // Locate the insertion slot and build the shifted table.
  always_comb begin
    int k;
    k = DEPTH;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (score_i > table_i[j]) k = j;
    end
    table_o = table_i;
    for (int j = 0; j < DEPTH; j++) begin
      if (j == k)     table_o[j] = score_i;
      else if (j > k) table_o[j] = table_i[(j > 0) ? j - 1 : 0];
    end
    rank_o = 3'(k);
    // A zero score never earns a place, even in an empty table.
    hit_o  = (k < DEPTH) && (score_i != '0);
  end

endmodule

// File: rtl/score_table_sequencer.sv
// Top-DEPTH high-score table kept in flash. Loads the table at boot,
// inserts qualifying scores in sorted order and rewrites the whole table
// (erase then sequential writes) after every change.
module score_table_sequencer
  import score_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int RISE_TIMEOUT = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DW-1:0]          new_score,
  input  logic                   score_valid,
  input  logic                   clear_table,
  output logic [DEPTH*DW-1:0]    table_out,
  output logic [2:0]             rank,
  output logic                   table_ready,
  output logic                   req_dropped,
  output logic                   error,
  score_table_sequencer_if.master fl
);

  localparam int TW = $clog2(RISE_TIMEOUT + 1);
  localparam logic [2:0] LAST = 3'(DEPTH - 1);

  state_e                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [DEPTH-1:0][DW-1:0] table_q, table_d;
  logic [2:0]               rank_q, rank_d;
  logic [DW-1:0]            score_q, score_d;
  logic                     drop_q, drop_d;

  logic                     wm, dw, dr;
  logic [DW-1:0]            rd_word, wdata_mux;
  logic [DEPTH-1:0][DW-1:0] ins_table;
  logic [2:0]               ins_rank;
  logic                     ins_hit;

  score_insert #(.DEPTH(DEPTH)) u_insert (
    .table_i (table_q),
    .score_i (score_q),
    .table_o (ins_table),
    .rank_o  (ins_rank),
    .hit_o   (ins_hit)
  );

  // Select the entry being written back to flash.
  always_comb begin
    wdata_mux = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (idx_q == 3'(j)) wdata_mux = table_q[j];
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_BOOT;
    else       state_q <= state_d;
  end

  // Next state, flash strobes and table/counter updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    table_d = table_q;
    rank_d  = rank_q;
    score_d = score_q;
    drop_d  = (score_valid || clear_table) && (state_q != S_IDLE);
    wm      = 1'b0;
    dw      = 1'b0;
    dr      = 1'b0;
    rd_word = (fl.frdata == ERASED_WORD) ? '0 : fl.frdata;

    case (state_q)
      S_BOOT: begin
        if (!fl.fbusy) begin
          idx_d   = '0;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        dr = 1'b1;
        if (fl.fbusy)                          state_d = S_RD_WAIT;
        else if (tmo_q == TW'(RISE_TIMEOUT))   state_d = S_ERROR;
        else                                   tmo_d   = tmo_q + TW'(1);
      end
      S_RD_WAIT: begin
        if (!fl.fbusy) begin
          for (int j = 0; j < DEPTH; j++) begin
            if (idx_q == 3'(j)) table_d[j] = rd_word;
          end
          if (idx_q == LAST) state_d = S_IDLE;
          else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_IDLE: begin
        if (clear_table) begin
          table_d = '0;
          rank_d  = 3'(DEPTH);
          state_d = S_ER_REQ;
        end else if (score_valid) begin
          score_d = new_score;
          state_d = S_INSERT;
        end
      end
      S_INSERT: begin
        if (ins_hit) begin
          table_d = ins_table;
          rank_d  = ins_rank;
          state_d = S_ER_REQ;
        end else begin
          rank_d  = 3'(DEPTH);
          state_d = S_IDLE;
        end
      end
      S_ER_REQ: begin
        wm = 1'b1;
        if (fl.fbusy)                          state_d = S_ER_WAIT;
        else if (tmo_q == TW'(RISE_TIMEOUT))   state_d = S_ERROR;
        else                                   tmo_d   = tmo_q + TW'(1);
      end
      S_ER_WAIT: begin
        wm = 1'b1;
        if (!fl.fbusy) begin
          idx_d   = '0;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        wm      = 1'b1;
        dw      = 1'b1;
        state_d = S_WR_RISE;
      end
      S_WR_RISE: begin
        wm = 1'b1;
        if (fl.fbusy)                          state_d = S_WR_WAIT;
        else if (tmo_q == TW'(RISE_TIMEOUT))   state_d = S_ERROR;
        else                                   tmo_d   = tmo_q + TW'(1);
      end
      S_WR_WAIT: begin
        wm = 1'b1;
        if (!fl.fbusy) begin
          if (idx_q == LAST) state_d = S_WR_DONE;
          else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_DONE: state_d = S_IDLE;
      S_ERROR:   state_d = S_ERROR;
      default:   state_d = S_BOOT;
    endcase

    // Every wait is measured from the moment its state is entered.
    if (state_d != state_q) tmo_d = '0;
  end

  // Table, index, timeout and request-drop registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q   <= '0;
      tmo_q   <= '0;
      table_q <= '0;
      rank_q  <= 3'(DEPTH);
      score_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      table_q <= table_d;
      rank_q  <= rank_d;
      score_q <= score_d;
      drop_q  <= drop_d;
    end
  end

  assign table_out    = table_q;
  assign rank         = rank_q;
  assign table_ready  = (state_q == S_IDLE);
  assign req_dropped  = drop_q;
  assign error        = (state_q == S_ERROR);
  assign fl.writemode = wm;
  assign fl.dowrite   = dw;
  assign fl.doread    = dr;
  assign fl.raddr     = AW'(idx_q);
  assign fl.wdata     = wdata_mux;

endmodule
